cdc_4phase_rx: RTL and testbench

Stand-alone receive endpoint of the 4-phase (return-to-zero) req/ack CDC handshake, living entirely in the destination clock domain. It synchronises the incoming asynchronous `req`, captures the sender-held data bus, presents each word downstream on a valid/ready interface, and drives `ack` back to the sender. `ack` is raised only after the downstream side accepts the word, so downstream backpressure stalls the sender.

---
 rtl/cdc_hs_pkg.sv | 15 +
 rtl/sync_2ff.sv | 24 ++
 rtl/cdc_4phase_rx.sv | 124 ++++++++++++
 tb/tb_cdc_4phase_rx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_hs_pkg.sv
// rtl/cdc_hs_pkg.sv - shared 4-phase handshake state encoding and synchroniser depth
package cdc_hs_pkg;

   // Number of flops in a single-bit CDC synchroniser chain
   localparam int SYNC_STAGES = 2;

   // Handshake FSM encoding, common to the receiver and the future sender.
   // WAIT_LOW differs from PRESENT only in bit 1, which marks the "ack phase".
   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_PRESENT  = 2'b01,
      ST_WAIT_LOW = 2'b11
   } hs_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - single-bit flop-chain synchroniser with async active-low reset
module sync_2ff
   import cdc_hs_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] stages;

   // Shift the asynchronous input through the synchroniser chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stages <= '0;
      end else begin
         stages <= {stages[SYNC_STAGES-2:0], d};
      end
   end

   assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_4phase_rx.sv
// rtl/cdc_4phase_rx.sv - 4-phase req/ack CDC receive endpoint; CDC_RX_WDOG_EN adds watchdog and err
module cdc_4phase_rx
   import cdc_hs_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic              o_clk,
   input  logic              o_rstn,
   input  logic              req,
   input  logic [DATA_W-1:0] i_data,
   output logic              ack,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   input  logic              o_ready
`ifdef CDC_RX_WDOG_EN
   ,
   output logic              err
`endif
);

   // A zero limit would make the watchdog fire on the first WAIT_LOW cycle
   if (TIMEOUT < 1) begin : g_timeout_check
      $error("cdc_4phase_rx: TIMEOUT must be at least 1");
   end

   logic      req_s;
   logic      capture;
   hs_state_e state;
   hs_state_e state_nxt;

   sync_2ff u_req_sync (
      .clk   (o_clk),
      .rst_n (o_rstn),
      .d     (req),
      .q     (req_s)
   );

   // Handshake state register
   always_ff @(posedge o_clk or negedge o_rstn) begin
      if (!o_rstn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: capture on req_s high, release on acceptance, re-arm only once req_s is low
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_s) begin
               state_nxt = ST_PRESENT;
               capture   = 1'b1;
            end
         end
         ST_PRESENT: begin
            // A req_s drop here is a sender violation; the word is still delivered
            if (o_ready) begin
               state_nxt = ST_WAIT_LOW;
            end
         end
         ST_WAIT_LOW: begin
            if (!req_s) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ack and o_valid are registered copies of the state being entered, so they are glitch-free and exclusive
   always_ff @(posedge o_clk or negedge o_rstn) begin
      if (!o_rstn) begin
         ack     <= 1'b0;
         o_valid <= 1'b0;
      end else begin
         ack     <= (state_nxt == ST_WAIT_LOW);
         o_valid <= (state_nxt == ST_PRESENT);
      end
   end

   // Sample the sender-held bus only in the capture cycle, when req_s guarantees it is stable
   always_ff @(posedge o_clk or negedge o_rstn) begin
      if (!o_rstn) begin
         o_data <= '0;
      end else if (capture) begin
         o_data <= i_data;
      end
   end

`ifdef CDC_RX_WDOG_EN
   localparam int RAW_W = $clog2(TIMEOUT + 1);
   localparam int CNT_W = (RAW_W < 8) ? 8 : ((RAW_W > 32) ? 32 : RAW_W);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] wdog_cnt;

   // Count cycles spent waiting for req to return low; saturate at the limit
   always_ff @(posedge o_clk or negedge o_rstn) begin
      if (!o_rstn) begin
         wdog_cnt <= '0;
      end else if (state != ST_WAIT_LOW) begin
         wdog_cnt <= '0;
      end else if (wdog_cnt != LIMIT) begin
         wdog_cnt <= wdog_cnt + 1'b1;
      end
   end

   // Sticky error: stuck req in WAIT_LOW or req dropped before the word was accepted
   always_ff @(posedge o_clk or negedge o_rstn) begin
      if (!o_rstn) begin
         err <= 1'b0;
      end else if ((wdog_cnt == LIMIT) || ((state == ST_PRESENT) && !req_s)) begin
         err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_cdc_4phase_rx.sv
// tb/tb_cdc_4phase_rx.sv - directed self-checking bench for cdc_4phase_rx (CDC_RX_WDOG_EN aware)
module tb_cdc_4phase_rx;

   logic       o_clk;
   logic       o_rstn;
   logic       req;
   logic [7:0] i_data;
   logic       ack;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_ready;
`ifdef CDC_RX_WDOG_EN
   logic       err;
`endif

   int total;
   int bad;

   cdc_4phase_rx #(
      .DATA_W  (8),
      .TIMEOUT (16)
   ) dut (
      .o_clk   (o_clk),
      .o_rstn  (o_rstn),
      .req     (req),
      .i_data  (i_data),
      .ack     (ack),
      .o_data  (o_data),
      .o_valid (o_valid),
      .o_ready (o_ready)
`ifdef CDC_RX_WDOG_EN
      ,
      .err     (err)
`endif
   );

   initial o_clk = 1'b0;
   always #5 o_clk = ~o_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // advance one clock; inputs change and outputs are sampled 1ns after the edge
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge o_clk);
         #1;
      end
   endtask

   task automatic pulse_reset();
      o_rstn = 1'b0;
      tick(2);
      o_rstn = 1'b1;
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      o_rstn  = 1'b0;
      req     = 1'b0;
      i_data  = 8'h00;
      o_ready = 1'b0;
      tick(3);
      chk("rst_ack", ack, 1'b0);
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_data", o_data, 8'h00);
      o_rstn = 1'b1;
      tick(2);

      // single transfer, o_ready held high
      i_data  = 8'hA5;
      o_ready = 1'b1;
      req     = 1'b1;
      tick(2);
      chk("single_valid_early", o_valid, 1'b0);
      tick();
      chk("single_valid", o_valid, 1'b1);
      chk("single_data", o_data, 8'hA5);
      chk("single_ack_low", ack, 1'b0);
      tick();
      chk("single_valid_pulse", o_valid, 1'b0);
      chk("single_ack_high", ack, 1'b1);
      req = 1'b0;
      tick(2);
      chk("single_ack_hold", ack, 1'b1);
      tick();
      chk("single_ack_drop", ack, 1'b0);
      tick(2);

      // backpressure for 10 cycles
      o_ready = 1'b0;
      i_data  = 8'h3C;
      req     = 1'b1;
      tick(3);
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", o_valid, 1'b1);
         chk("bp_data", o_data, 8'h3C);
         chk("bp_ack", ack, 1'b0);
         tick();
      end
      o_ready = 1'b1;
      tick();
      chk("bp_ack_rise", ack, 1'b1);
      chk("bp_valid_clear", o_valid, 1'b0);
      req = 1'b0;
      tick(3);
      chk("bp_ack_fall", ack, 1'b0);
      tick(2);

      // sticky req: no duplicate while req stays high
      begin : sticky
         int vcnt;
         logic [7:0] seen;
         vcnt   = 0;
         seen   = 8'h00;
         i_data = 8'h55;
         req    = 1'b1;
         tick(4);
         chk("sticky_ack", ack, 1'b1);
         for (int i = 0; i < 50; i++) begin
            tick();
            if (o_valid) vcnt++;
         end
         chk("sticky_no_dup", vcnt, 0);
         chk("sticky_ack_held", ack, 1'b1);
         req = 1'b0;
         tick(3);
         chk("sticky_ack_fall", ack, 1'b0);
         i_data = 8'h77;
         req    = 1'b1;
         vcnt   = 0;
         for (int i = 0; i < 10; i++) begin
            tick();
            if (o_valid) begin
               vcnt++;
               seen = o_data;
            end
         end
         chk("sticky_one_word", vcnt, 1);
         chk("sticky_word", seen, 8'h77);
         req = 1'b0;
         tick(4);
      end

      // back-to-back words 0..15 from a model sender with random o_ready
      begin : b2b
         int   rx_idx;
         int   tx_word;
         int   cyc;
         logic ack_m1;
         logic ack_m2;
         logic overlap;
         rx_idx  = 0;
         tx_word = 0;
         cyc     = 0;
         ack_m1  = 1'b0;
         ack_m2  = 1'b0;
         overlap = 1'b0;
         while (rx_idx < 16 && cyc < 3000) begin
            o_ready = 1'($urandom_range(0, 1));
            if (o_valid && o_ready) begin
               chk("b2b_word", o_data, rx_idx);
               rx_idx++;
            end
            tick();
            cyc++;
            if (o_valid && ack) overlap = 1'b1;
            ack_m2 = ack_m1;
            ack_m1 = ack;
            if (!req && !ack_m2 && tx_word < 16) begin
               i_data = 8'(tx_word);
               req    = 1'b1;
            end else if (req && ack_m2) begin
               req = 1'b0;
               tx_word++;
            end
         end
         chk("b2b_count", rx_idx, 16);
         chk("b2b_exclusive", overlap, 1'b0);
         req     = 1'b0;
         o_ready = 1'b0;
         tick(4);
         chk("b2b_idle_ack", ack, 1'b0);
      end

      // asynchronous reset while a word is presented
      i_data  = 8'hC3;
      o_ready = 1'b0;
      req     = 1'b1;
      tick(3);
      chk("rstmid_valid", o_valid, 1'b1);
      #2;
      o_rstn = 1'b0;
      #1;
      chk("rstmid_async_valid", o_valid, 1'b0);
      chk("rstmid_async_ack", ack, 1'b0);
      chk("rstmid_async_data", o_data, 8'h00);
      tick();
      o_rstn = 1'b1;
      tick(2);
      chk("rstmid_wait", o_valid, 1'b0);
      tick();
      chk("rstmid_recap_valid", o_valid, 1'b1);
      chk("rstmid_recap_data", o_data, 8'hC3);
      o_ready = 1'b1;
      tick();
      chk("rstmid_ack", ack, 1'b1);
      req = 1'b0;
      tick(4);

`ifdef CDC_RX_WDOG_EN
      // watchdog: req stuck high in WAIT_LOW
      pulse_reset();
      chk("wdog_rst_err", err, 1'b0);
      i_data  = 8'h11;
      o_ready = 1'b1;
      req     = 1'b1;
      tick(4);
      chk("wdog_ack", ack, 1'b1);
      tick(10);
      chk("wdog_not_yet", err, 1'b0);
      tick(10);
      chk("wdog_err", err, 1'b1);
      req = 1'b0;
      tick(5);
      chk("wdog_sticky", err, 1'b1);

      // early req drop while presenting
      pulse_reset();
      chk("early_rst_err", err, 1'b0);
      i_data  = 8'h9E;
      o_ready = 1'b0;
      req     = 1'b1;
      tick(3);
      chk("early_valid", o_valid, 1'b1);
      req = 1'b0;
      tick(3);
      chk("early_err", err, 1'b1);
      chk("early_still_valid", o_valid, 1'b1);
      chk("early_data", o_data, 8'h9E);
      o_ready = 1'b1;
      tick();
      chk("early_ack", ack, 1'b1);
      tick();
      chk("early_ack_drop", ack, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
